// File: rtl/rsa_decrypt.sv
// RSA decryption m = c^d mod n: left-to-right square-and-multiply over an interleaved
// shift-add modular multiplier. Optional input range check enabled by RSA_DEC_RANGE_CHECK_EN.
module rsa_decrypt #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cipher,
  input  logic [WIDTH-1:0] d_key,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] message,
  output logic             busy,
  output logic             done
`ifdef RSA_DEC_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StSqr, StMul, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] c_q, d_q, n_q, acc_q, p_q;
  logic [IW-1:0]    idx_q, cnt_q;

  // One step of x*y mod n: y bits come from acc (MSB first), x is acc or c.
  logic [WIDTH-1:0] mul_x, p_next;
  logic             mul_bit;
  logic [WIDTH:0]   n_ext, t_dbl, t_red, t_sum, t_fin;

  always_comb begin
    mul_x   = (state_q == StMul) ? c_q : acc_q;
    mul_bit = acc_q[cnt_q];
    n_ext   = {1'b0, n_q};
    t_dbl   = {p_q, 1'b0};
    t_red   = (t_dbl >= n_ext) ? t_dbl - n_ext : t_dbl;
    t_sum   = t_red + {1'b0, mul_x};
    if (mul_bit) begin
      t_fin = (t_sum >= n_ext) ? t_sum - n_ext : t_sum;
    end else begin
      t_fin = t_red;
    end
    p_next  = t_fin[WIDTH-1:0];
  end

  logic reject;
`ifdef RSA_DEC_RANGE_CHECK_EN
  assign reject = (n < WIDTH'(2)) || (cipher >= n);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      message <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef RSA_DEC_RANGE_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            c_q   <= cipher;
            d_q   <= d_key;
            n_q   <= n;
            acc_q <= WIDTH'(1);
            p_q   <= '0;
            idx_q <= IW'(WIDTH - 1);
            cnt_q <= IW'(WIDTH - 1);
            if (reject) begin
              state_q <= StDone;
              done    <= 1'b1;
              message <= '0;
`ifdef RSA_DEC_RANGE_CHECK_EN
              err     <= 1'b1;
`endif
            end else begin
              state_q <= StSqr;
              busy    <= 1'b1;
            end
          end
        end
        StSqr, StMul: begin
          if (cnt_q != '0) begin
            p_q   <= p_next;
            cnt_q <= cnt_q - IW'(1);
          end else begin
            // Multiply finished: commit product and pick the next phase.
            p_q   <= '0;
            cnt_q <= IW'(WIDTH - 1);
            acc_q <= p_next;
            if (state_q == StSqr && d_q[idx_q]) begin
              state_q <= StMul;
            end else if (idx_q == '0) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              message <= p_next;
            end else begin
              idx_q   <= idx_q - IW'(1);
              state_q <= StSqr;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
`ifdef RSA_DEC_RANGE_CHECK_EN
          err     <= 1'b0;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
